// File: rtl/usb_tx_pkt_ctrl.sv
// usb_tx_pkt_ctrl: d_orig_gen packet sequencer SYNC/PID/payload/CRC16 (USB_TX_CRC16_EN)/EOP; ports clk n_rst tx_start tx_pid tx_len fifo_rdata fifo_empty -> fifo_rd sending data ready tx_done tx_err
module usb_tx_pkt_ctrl #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_LEN = 64,
  parameter int EOP_CYCLES = 24,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          tx_start,
  input  logic [3:0]    tx_pid,
  input  logic [LW-1:0] tx_len,
  input  logic [7:0]    fifo_rdata,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  output logic          sending,
  output logic [7:0]    data,
  output logic          ready,
  output logic          tx_done,
  output logic          tx_err
);
  localparam int BYTE_CYCLES = 8 * CLKS_PER_BIT;
  localparam int CW = $clog2(BYTE_CYCLES > EOP_CYCLES ? BYTE_CYCLES : EOP_CYCLES);
  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP
`ifdef USB_TX_CRC16_EN
    , CRC_LO, CRC_HI
`endif
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] rem, rem_n;
  logic [3:0] pid, pid_n;
  logic [7:0] data_n;
  logic err_n, done_n, last;
`ifdef USB_TX_CRC16_EN
  logic [15:0] crc, crc_n;
  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 16'hA001 : r >> 1;
    return r;
  endfunction
`endif
  assign sending = state != IDLE && state != EOP;
  assign ready = state == IDLE;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      pid <= '0;
      data <= 8'h00;
      tx_err <= 1'b0;
      tx_done <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc <= 16'h0000;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rem <= rem_n;
      pid <= pid_n;
      data <= data_n;
      tx_err <= err_n;
      tx_done <= done_n;
`ifdef USB_TX_CRC16_EN
      crc <= crc_n;
`endif
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rem_n = rem;
    pid_n = pid;
    data_n = data;
    err_n = tx_err;
    done_n = 1'b0;
    fifo_rd = 1'b0;
`ifdef USB_TX_CRC16_EN
    crc_n = crc;
`endif
    last = cnt == CW'(BYTE_CYCLES - 1);
    case (state)
      IDLE: if (tx_start) begin
        cnt_n = '0;
        err_n = tx_len > LW'(MAX_LEN);
        state_n = err_n ? EOP : SYNC;
        data_n = err_n ? 8'h00 : 8'h80;
        pid_n = tx_pid;
        rem_n = tx_len;
`ifdef USB_TX_CRC16_EN
        crc_n = 16'hFFFF;
`endif
      end
      EOP: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(EOP_CYCLES - 1)) begin
          cnt_n = '0;
          state_n = IDLE;
          done_n = 1'b1;
        end
      end
      default: begin
        cnt_n = last ? '0 : cnt + CW'(1);
        if (last) case (state)
          SYNC: begin
            state_n = PID;
            data_n = {~pid, pid};
          end
          PID, DATA: if (rem != '0) begin
            fifo_rd = !fifo_empty;
            state_n = fifo_empty ? EOP : DATA;
            data_n = fifo_empty ? 8'h00 : fifo_rdata;
            rem_n = fifo_empty ? rem : rem - LW'(1);
            err_n = tx_err | fifo_empty;
`ifdef USB_TX_CRC16_EN
            crc_n = fifo_empty ? crc : crc16(crc, fifo_rdata);
`endif
          end else begin
`ifdef USB_TX_CRC16_EN
            state_n = CRC_LO;
            data_n = ~crc[7:0];
`else
            state_n = EOP;
            data_n = 8'h00;
`endif
          end
`ifdef USB_TX_CRC16_EN
          CRC_LO: begin
            state_n = CRC_HI;
            data_n = ~crc[15:8];
          end
`endif
          default: begin
            state_n = EOP;
            data_n = 8'h00;
          end
        endcase
      end
    endcase
  end
endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// tb_usb_tx_pkt_ctrl: directed and randomized packets against a slot-list reference model of usb_tx_pkt_ctrl
module tb_usb_tx_pkt_ctrl;
`ifdef USB_TX_CRC16_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic tx_start = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [6:0] tx_len = 7'd0;
  logic [7:0] fifo_rdata = 8'h00;
  logic fifo_empty = 1'b1;
  logic fifo_rd, sending, ready, tx_done, tx_err;
  logic [7:0] data;
  logic [7:0] fq[$];
  logic [7:0] pay[$];
  logic [7:0] got[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_pop, bad_pop, m_hi, m_pop, nd;

  usb_tx_pkt_ctrl dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_pid(tx_pid), .tx_len(tx_len),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .sending(sending),
    .data(data), .ready(ready), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    for (int b = 0; b < 8; b++) begin
      logic fb;
      fb = c[0] ^ d[b];
      c = {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
    end
    return c;
  endfunction

  task automatic refresh();
    fifo_empty = fq.size() == 0;
    fifo_rdata = fifo_empty ? 8'h00 : fq[0];
  endtask

  task automatic tick();
    logic p;
    p = fifo_rd;
    if (p && fifo_empty) bad_pop++;
    if (p) n_pop++;
    @(posedge clk);
    #1;
    if (p && fq.size() > 0) void'(fq.pop_front());
    refresh();
    #1;
  endtask

  task automatic fill_pay();
    pay = {};
    for (int i = 0; i < 70; i++) pay.push_back(8'($urandom));
  endtask

  task automatic run_pkt(input logic [3:0] pid, input int len, input int avail, input bit poke);
    logic [7:0] slots[$];
    logic [15:0] c;
    logic [7:0] exp_d;
    logic exp_err, exp_s, exp_r, exp_t;
    int exp_hi, exp_pop, bad, first_bad, pk;
    fq = {};
    for (int i = 0; i < avail; i++) fq.push_back(pay[i]);
    refresh();
    if (len > 64) begin
      exp_err = 1'b1;
      exp_pop = 0;
    end else begin
      exp_pop = len < avail ? len : avail;
      exp_err = avail < len;
      slots.push_back(8'h80);
      slots.push_back({~pid, pid});
      for (int i = 0; i < exp_pop; i++) slots.push_back(pay[i]);
      if (!exp_err && C == 1) begin
        c = 16'hFFFF;
        for (int i = 0; i < len; i++) c = crc_byte(c, pay[i]);
        c = ~c;
        slots.push_back(c[7:0]);
        slots.push_back(c[15:8]);
      end
    end
    exp_hi = slots.size() * 64;
    pk = exp_hi > 200 ? 200 : 10;
    n_pop = 0;
    bad_pop = 0;
    m_hi = 0;
    got = {};
    tx_pid = pid;
    tx_len = len[6:0];
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < exp_hi + 27; i++) begin
      exp_s = i < exp_hi;
      exp_d = exp_s ? slots[i / 64] : 8'h00;
      exp_r = i >= exp_hi + 24;
      exp_t = i == exp_hi + 24;
      if (sending) m_hi++;
      if (sending && i % 64 == 0) got.push_back(data);
      if ({sending, data, ready, tx_done} !== {exp_s, exp_d, exp_r, exp_t}) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      tx_start = poke && i == pk;
      tx_pid = 4'($urandom);
      tx_len = 7'd3;
      tick();
    end
    tx_start = 1'b0;
    m_pop = n_pop;
    chk($sformatf("seq_len%0d_first_bad_%0d", len, first_bad), bad, 0);
    chk($sformatf("pops_len%0d", len), n_pop, exp_pop);
    chk($sformatf("pop_while_empty_len%0d", len), bad_pop, 0);
    chk($sformatf("tx_err_len%0d", len), tx_err, exp_err);
  endtask

  initial begin
    int len, avail;
    #3 n_rst = 1'b0;
    refresh();
    repeat (3) tick();
    chk("rst_sending", sending, 0);
    chk("rst_ready", ready, 1);
    chk("rst_data", data, 8'h00);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx_err", tx_err, 0);
    n_rst = 1'b1;
    repeat (2) tick();

    fill_pay();
    pay[0] = 8'h6E;
    pay[1] = 8'h01;
    pay[2] = 8'hFF;
    run_pkt(4'h3, 3, 3, 1'b1);
    chk("norm_sending_clocks", m_hi, 64 * (5 + 2 * C));
    chk("norm_pop_count", m_pop, 3);
    chk("norm_pid_byte", got[1], 8'hC3);
    chk("norm_byte0", got[2], 8'h6E);
    chk("norm_byte1", got[3], 8'h01);
    chk("norm_byte2", got[4], 8'hFF);

    run_pkt(4'($urandom), 0, 0, 1'b0);
    chk("len0_pops", m_pop, 0);

    fill_pay();
    run_pkt(4'h9, 4, 2, 1'b0);
    chk("underrun_sending_clocks", m_hi, 256);
    run_pkt(4'h1, 2, 2, 1'b0);

    run_pkt(4'h5, 65, 3, 1'b1);
    chk("badlen_sending_clocks", m_hi, 0);

    fill_pay();
    fq = {};
    for (int i = 0; i < 5; i++) fq.push_back(pay[i]);
    refresh();
    tx_pid = 4'hA;
    tx_len = 7'd5;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (64 * 4 + 10) tick();
    n_rst = 1'b0;
    #1;
    chk("midrst_sending", sending, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_data", data, 8'h00);
    chk("midrst_tx_err", tx_err, 0);
    chk("midrst_fifo_rd", fifo_rd, 0);
    repeat (2) tick();
    n_rst = 1'b1;
    nd = 0;
    repeat (40) begin
      nd += int'(tx_done);
      tick();
    end
    chk("midrst_no_done", nd, 0);

    fill_pay();
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    run_pkt(4'h3, 9, 9, 1'b1);
    chk("crcpkt_sending_clocks", m_hi, 64 * (11 + 2 * C));
`ifdef USB_TX_CRC16_EN
    chk("crc_lo", got[11], 8'hC8);
    chk("crc_hi", got[12], 8'hB4);
`endif

    fill_pay();
    run_pkt(4'($urandom), 64, 64, 1'b0);

    for (int k = 0; k < 10; k++) begin
      fill_pay();
      len = $urandom_range(0, 4) == 0 ? 65 + int'($urandom_range(0, 62)) : int'($urandom_range(0, 16));
      avail = (len > 0 && len <= 64 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1))
                                                                   : (len > 64 ? 3 : len + int'($urandom_range(0, 2)));
      run_pkt(4'($urandom), len, avail, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
